// File: rtl/counter_pkg.sv
// Shared constants and helpers for the multi-mode counter bank.
// Optional capture path is enabled with COUNTER_CAPTURE_EN.
package counter_pkg;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic DIR_UP    = 1'b1;

  localparam int MAX_CH = 16;

  function automatic int slice_lo(
    input int idx,
    input int width
  );
    return idx * width;
  endfunction

  function automatic bit slice_ok(
    input int num_ch,
    input int width,
    input int total
  );
    return (num_ch >= 1) && (num_ch <= MAX_CH)
        && (width > 0) && (num_ch * width == total);
  endfunction

endpackage

// File: rtl/counter_channel.sv
// One counter channel: clear/load/step with wrap or saturate at limit.
// COUNTER_CAPTURE_EN adds a snapshot register of the pre-edge count.
module counter_channel
  import counter_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         a_reset_n,
  input  logic         reset_i,
  input  logic         load_i,
  input  logic [W-1:0] load_data_i,
  input  logic         increment_i,
  input  logic         up_down_i,
  input  logic         mode_i,
  input  logic [W-1:0] limit_i,
  input  logic         flag_clr_i,
`ifdef COUNTER_CAPTURE_EN
  input  logic         capture_i,
  output logic [W-1:0] capture_val_o,
  output logic         capture_vld_o,
`endif
  output logic [W-1:0] counter_o,
  output logic         tc_o,
  output logic         flag_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         tc_q, tc_d;
  logic         flag_q, flag_d;
  logic         bnd;

  always_comb begin
    cnt_d = cnt_q;
    bnd   = 1'b0;
    if (reset_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_data_i;
    end else if (increment_i) begin
      unique case (up_down_i)
        DIR_UP: begin
          if (cnt_q < limit_i) begin
            cnt_d = cnt_q + W'(1);
          end else begin
            bnd   = 1'b1;
            cnt_d = (mode_i == MODE_SAT) ? limit_i : '0;
          end
        end
        DIR_DOWN: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
          end else begin
            bnd   = 1'b1;
            cnt_d = (mode_i == MODE_WRAP) ? limit_i : '0;
          end
        end
      endcase
    end
    tc_d   = bnd;
    // A boundary in the same cycle as flag_clr keeps the flag set.
    flag_d = bnd | (flag_q & ~flag_clr_i);
  end

  always_ff @(posedge clk or negedge a_reset_n) begin
    if (!a_reset_n) begin
      cnt_q  <= '0;
      tc_q   <= 1'b0;
      flag_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tc_q   <= tc_d;
      flag_q <= flag_d;
    end
  end

  assign counter_o = cnt_q;
  assign tc_o      = tc_q;
  assign flag_o    = flag_q;

`ifdef COUNTER_CAPTURE_EN
  logic [W-1:0] cap_val_q;
  logic         cap_vld_q;

  always_ff @(posedge clk or negedge a_reset_n) begin
    if (!a_reset_n) begin
      cap_val_q <= '0;
      cap_vld_q <= 1'b0;
    end else if (reset_i) begin
      cap_vld_q <= 1'b0;
    end else if (capture_i) begin
      cap_val_q <= cnt_q;
      cap_vld_q <= 1'b1;
    end
  end

  assign capture_val_o = cap_val_q;
  assign capture_vld_o = cap_vld_q;
`endif

endmodule

// File: rtl/multi_mode_counter.sv
// Bank of NUM_CH independent counter channels with packed buses.
// Optional capture ports are present only with COUNTER_CAPTURE_EN.
module multi_mode_counter
  import counter_pkg::*;
#(
  parameter int COUNT_WIDTH = 8,
  parameter int NUM_CH      = 4
) (
  input  logic                          clk,
  input  logic                          a_reset_n,
  input  logic [NUM_CH-1:0]             reset,
  input  logic [NUM_CH-1:0]             load,
  input  logic [NUM_CH*COUNT_WIDTH-1:0] load_data,
  input  logic [NUM_CH-1:0]             increment,
  input  logic [NUM_CH-1:0]             up_down,
  input  logic [NUM_CH-1:0]             mode,
  input  logic [NUM_CH*COUNT_WIDTH-1:0] limit,
  input  logic [NUM_CH-1:0]             flag_clr,
  output logic [NUM_CH*COUNT_WIDTH-1:0] counter,
  output logic [NUM_CH-1:0]             tc,
  output logic [NUM_CH-1:0]             flag
`ifdef COUNTER_CAPTURE_EN
  ,
  input  logic [NUM_CH-1:0]             capture,
  output logic [NUM_CH*COUNT_WIDTH-1:0] capture_val,
  output logic [NUM_CH-1:0]             capture_vld
`endif
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam int Lo = slice_lo(i, COUNT_WIDTH);

    counter_channel #(
      .W (COUNT_WIDTH)
    ) u_ch (
      .clk          (clk),
      .a_reset_n    (a_reset_n),
      .reset_i      (reset[i]),
      .load_i       (load[i]),
      .load_data_i  (load_data[Lo +: COUNT_WIDTH]),
      .increment_i  (increment[i]),
      .up_down_i    (up_down[i]),
      .mode_i       (mode[i]),
      .limit_i      (limit[Lo +: COUNT_WIDTH]),
      .flag_clr_i   (flag_clr[i]),
`ifdef COUNTER_CAPTURE_EN
      .capture_i    (capture[i]),
      .capture_val_o(capture_val[Lo +: COUNT_WIDTH]),
      .capture_vld_o(capture_vld[i]),
`endif
      .counter_o    (counter[Lo +: COUNT_WIDTH]),
      .tc_o         (tc[i]),
      .flag_o       (flag[i])
    );
  end

endmodule

// File: tb/tb_multi_mode_counter.sv
// Self-checking bench for multi_mode_counter: vector table, corner
// sequences and randomized traffic against a behavioural model.
module tb_multi_mode_counter;
  import counter_pkg::*;

  localparam int W = 8;
  localparam int N = 4;

  logic clk = 1'b0;
  logic clk_run = 1'b1;
  logic a_reset_n = 1'b1;

  logic [N-1:0] rst_v, ld_v, inc_v, ud_v, md_v, fc_v;
  logic [W-1:0] ldd [N];
  logic [W-1:0] lim [N];

  logic [N*W-1:0] load_data, limit, counter;
  logic [N-1:0]   tc, flag;

`ifdef COUNTER_CAPTURE_EN
  logic [N-1:0]   cap_v;
  logic [N*W-1:0] capture_val;
  logic [N-1:0]   capture_vld;
  int m_cv [N];
  bit m_cvld [N];
`endif

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign load_data[g*W +: W] = ldd[g];
    assign limit[g*W +: W]     = lim[g];
  end

  always #5 clk = clk_run ? ~clk : 1'b0;

  multi_mode_counter #(
    .COUNT_WIDTH(W),
    .NUM_CH     (N)
  ) dut (
    .clk        (clk),
    .a_reset_n  (a_reset_n),
    .reset      (rst_v),
    .load       (ld_v),
    .load_data  (load_data),
    .increment  (inc_v),
    .up_down    (ud_v),
    .mode       (md_v),
    .limit      (limit),
    .flag_clr   (fc_v),
    .counter    (counter),
    .tc         (tc),
    .flag       (flag)
`ifdef COUNTER_CAPTURE_EN
    ,
    .capture    (cap_v),
    .capture_val(capture_val),
    .capture_vld(capture_vld)
`endif
  );

  int checks = 0;
  int errors = 0;

  int m_cnt [N];
  bit m_tc [N];
  bit m_flag [N];

  task automatic chk(input string nm, input int ch,
                     input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s ch%0d got %0d want %0d", nm, ch, act, exp);
    end
  endtask

  function automatic int cnt_of(input int ch);
    return int'(counter[ch*W +: W]);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      m_cnt[c] = 0;
      m_tc[c] = 1'b0;
      m_flag[c] = 1'b0;
`ifdef COUNTER_CAPTURE_EN
      m_cv[c] = 0;
      m_cvld[c] = 1'b0;
`endif
    end
  endtask

  task automatic check_all();
    for (int c = 0; c < N; c++) begin
      chk("model_cnt", c, cnt_of(c), m_cnt[c]);
      chk("model_tc", c, int'(tc[c]), int'(m_tc[c]));
      chk("model_flag", c, int'(flag[c]), int'(m_flag[c]));
`ifdef COUNTER_CAPTURE_EN
      chk("model_cvld", c, int'(capture_vld[c]), int'(m_cvld[c]));
      chk("model_cval", c, int'(capture_val[c*W +: W]), m_cv[c]);
`endif
    end
  endtask

  // Next state from the counting rules, evaluated on pre-edge inputs.
  task automatic tick();
    int nc [N];
    bit nt [N];
    bit nf [N];
    for (int c = 0; c < N; c++) begin
      int v = m_cnt[c];
      int l = int'(lim[c]);
      bit b = 1'b0;
      bit sat = (md_v[c] == MODE_SAT);
      if (rst_v[c]) v = 0;
      else if (ld_v[c]) v = int'(ldd[c]);
      else if (inc_v[c]) begin
        if (ud_v[c] == DIR_UP) begin
          if (v >= l) begin
            b = 1'b1;
            v = sat ? l : 0;
          end else v = v + 1;
        end else begin
          if (v == 0) begin
            b = 1'b1;
            v = sat ? 0 : l;
          end else v = v - 1;
        end
      end
      nc[c] = v;
      nt[c] = b;
      nf[c] = b || (m_flag[c] && !fc_v[c]);
`ifdef COUNTER_CAPTURE_EN
      if (rst_v[c]) m_cvld[c] = 1'b0;
      else if (cap_v[c]) begin
        m_cvld[c] = 1'b1;
        m_cv[c] = m_cnt[c];
      end
`endif
    end
    @(posedge clk);
    #1;
    for (int c = 0; c < N; c++) begin
      m_cnt[c] = nc[c];
      m_tc[c] = nt[c];
      m_flag[c] = nf[c];
    end
    check_all();
  endtask

  task automatic idle_strobes();
    rst_v = '0;
    ld_v  = '0;
    inc_v = '0;
    fc_v  = '0;
`ifdef COUNTER_CAPTURE_EN
    cap_v = '0;
`endif
  endtask

  typedef struct {
    int ch;
    bit rst;
    bit ld;
    bit inc;
    bit up;
    bit sat;
    int ldd;
    int lim;
    int e_cnt;
    bit e_tc;
  } vec_t;

  vec_t tbl [$];

  task automatic addv(input int ch, input bit rst, input bit ld,
                      input bit inc, input bit up, input bit sat,
                      input int d, input int l,
                      input int ec, input bit et);
    vec_t v;
    v.ch = ch; v.rst = rst; v.ld = ld; v.inc = inc;
    v.up = up; v.sat = sat; v.ldd = d; v.lim = l;
    v.e_cnt = ec; v.e_tc = et;
    tbl.push_back(v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_strobes();
    ud_v = '0;
    md_v = '0;
    for (int c = 0; c < N; c++) begin
      ldd[c] = '0;
      lim[c] = '0;
    end
`ifdef COUNTER_CAPTURE_EN
    cap_v = '0;
`endif
    model_reset();

    // Power-on reset before any clock edge.
    #2 a_reset_n = 1'b0;
    #1;
    for (int c = 0; c < N; c++) begin
      chk("por_cnt", c, cnt_of(c), 0);
      chk("por_tc", c, int'(tc[c]), 0);
      chk("por_flag", c, int'(flag[c]), 0);
    end
    #9 a_reset_n = 1'b1;

    // ch0: limit 5, wrap, up.
    addv(0, 1, 0, 0, 1, 0, 0, 5, 0, 0);
    for (int k = 1; k <= 5; k++) addv(0, 0, 0, 1, 1, 0, 0, 5, k, 0);
    addv(0, 0, 0, 1, 1, 0, 0, 5, 0, 1);
    addv(0, 0, 0, 1, 1, 0, 0, 5, 1, 0);
    // ch1: limit 3, saturate, down from 2 then up.
    addv(1, 0, 1, 0, 0, 1, 2, 3, 2, 0);
    addv(1, 0, 0, 1, 0, 1, 0, 3, 1, 0);
    addv(1, 0, 0, 1, 0, 1, 0, 3, 0, 0);
    addv(1, 0, 0, 1, 0, 1, 0, 3, 0, 1);
    addv(1, 0, 0, 1, 0, 1, 0, 3, 0, 1);
    addv(1, 0, 0, 1, 1, 1, 0, 3, 1, 0);
    addv(1, 0, 0, 1, 1, 1, 0, 3, 2, 0);
    addv(1, 0, 0, 1, 1, 1, 0, 3, 3, 0);
    addv(1, 0, 0, 1, 1, 1, 0, 3, 3, 1);
    addv(1, 0, 0, 1, 1, 1, 0, 3, 3, 1);

    foreach (tbl[i]) begin
      int c = tbl[i].ch;
      idle_strobes();
      rst_v[c] = tbl[i].rst;
      ld_v[c]  = tbl[i].ld;
      inc_v[c] = tbl[i].inc;
      ud_v[c]  = tbl[i].up;
      md_v[c]  = tbl[i].sat;
      ldd[c]   = W'(tbl[i].ldd);
      lim[c]   = W'(tbl[i].lim);
      tick();
      chk("tbl_cnt", c, cnt_of(c), tbl[i].e_cnt);
      chk("tbl_tc", c, int'(tc[c]), int'(tbl[i].e_tc));
    end

    idle_strobes();
    chk("ch0_flag_set", 0, int'(flag[0]), 1);
    fc_v[0] = 1'b1;
    tick();
    chk("ch0_flag_clr", 0, int'(flag[0]), 0);

    // ch2: reset beats load beats increment; load beats increment.
    idle_strobes();
    lim[2] = 8'hFF;
    ud_v[2] = DIR_UP;
    md_v[2] = MODE_WRAP;
    ldd[2] = 8'h07;
    rst_v[2] = 1'b1; ld_v[2] = 1'b1; inc_v[2] = 1'b1;
    tick();
    chk("ch2_rst_prio", 2, cnt_of(2), 0);
    rst_v[2] = 1'b0;
    tick();
    chk("ch2_ld_prio", 2, cnt_of(2), 8'h07);
    lim[2] = 8'h10;
    ldd[2] = 8'hF0;
    inc_v[2] = 1'b0;
    tick();
    chk("ch2_ld_above", 2, cnt_of(2), 8'hF0);
    ld_v[2] = 1'b0;
    inc_v[2] = 1'b1;
    tick();
    chk("ch2_above_wrap", 2, cnt_of(2), 0);
    chk("ch2_above_tc", 2, int'(tc[2]), 1);

    // ch3: flag_clr coincident with boundary; ch0 counts alongside.
    idle_strobes();
    lim[0] = 8'd9;
    inc_v[0] = 1'b1;
    ud_v[0] = DIR_UP;
    fc_v[3] = 1'b1;
    tick();
    chk("ch3_pre_clr", 3, int'(flag[3]), 0);
    lim[3] = 8'd0;
    md_v[3] = MODE_WRAP;
    ud_v[3] = DIR_UP;
    inc_v[3] = 1'b1;
    tick();
    chk("ch3_coinc_flag", 3, int'(flag[3]), 1);
    chk("ch3_coinc_tc", 3, int'(tc[3]), 1);
    chk("ch3_lim0_cnt", 3, cnt_of(3), 0);
    inc_v[3] = 1'b0;
    tick();
    chk("ch3_clr_flag", 3, int'(flag[3]), 0);
    chk("ch3_tc_drop", 3, int'(tc[3]), 0);

`ifdef COUNTER_CAPTURE_EN
    idle_strobes();
    lim[0] = 8'd10;
    md_v[0] = MODE_WRAP;
    ud_v[0] = DIR_UP;
    rst_v[0] = 1'b1;
    tick();
    rst_v[0] = 1'b0;
    inc_v[0] = 1'b1;
    repeat (4) tick();
    cap_v[0] = 1'b1;
    tick();
    chk("cap_val", 0, int'(capture_val[W-1:0]), 4);
    chk("cap_vld", 0, int'(capture_vld[0]), 1);
    cap_v[0] = 1'b0;
    rst_v[0] = 1'b1;
    tick();
    chk("cap_vld_rst", 0, int'(capture_vld[0]), 0);
`endif

    // Randomized traffic, with an async reset while the clock is stopped.
    for (int n = 0; n < 400; n++) begin
      for (int c = 0; c < N; c++) begin
        rst_v[c] = ($urandom_range(31) == 0);
        ld_v[c]  = ($urandom_range(15) == 0);
        inc_v[c] = ($urandom_range(3) != 0);
        ud_v[c]  = $urandom_range(1) == 1;
        md_v[c]  = $urandom_range(1) == 1;
        fc_v[c]  = ($urandom_range(15) == 0);
        ldd[c]   = W'($urandom_range(12));
        if ($urandom_range(19) == 0)
          lim[c] = ($urandom_range(7) == 0) ? 8'hFF : W'($urandom_range(7));
`ifdef COUNTER_CAPTURE_EN
        cap_v[c] = ($urandom_range(7) == 0);
`endif
      end
      tick();
      if (n == 200) begin
        idle_strobes();
        clk_run = 1'b0;
        #20 a_reset_n = 1'b0;
        #1;
        for (int c = 0; c < N; c++) begin
          chk("async_cnt", c, cnt_of(c), 0);
          chk("async_tc", c, int'(tc[c]), 0);
          chk("async_flag", c, int'(flag[c]), 0);
        end
        model_reset();
        #3 a_reset_n = 1'b1;
        #2 clk_run = 1'b1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
